// File: rtl/light_conflict_monitor.sv
// Purpose: safety monitor between the traffic-light controller and the lamp drivers. It passes legal lamp commands
//          through, and on a fault it forces flashing red.
// Latency: 2 cycles from command input to lamp output (input register S, then output register); no comb in->out path.
// Backpressure: none. The command stream is sampled every cycle, and a fault holds flashing red until FACK or reset.
//
// Ports:
//   i_ck, i_clrn                   clock (rising edge) and asynchronous active-low reset
//   i_grn1..i_red2                 lamp commands from the controller, {G,Y,R} per direction
//   i_fack                         fault acknowledge; accepted in FAULT_FLASH only while the sampled commands are good
//   o_lg1..o_lr2                   registered lamp drives
//   o_fault, o_fcode               latched fault flag and reason (01 conflict, 10 illegal code, 11 yellow violation)
// Optional feature: define MONITOR_YLW_EN to compile in the short/skipped-yellow check (FCODE 11).
module light_conflict_monitor #(
    parameter int unsigned STARTUP      = 8,
    parameter int unsigned CONFLICT_DEB = 2,
    parameter int unsigned MIN_YLW      = 3,
    parameter int unsigned FLASH_HALF   = 4
) (
    input  logic       i_ck,
    input  logic       i_clrn,
    input  logic       i_grn1,
    input  logic       i_ylw1,
    input  logic       i_red1,
    input  logic       i_grn2,
    input  logic       i_ylw2,
    input  logic       i_red2,
    input  logic       i_fack,
    output logic       o_lg1,
    output logic       o_ly1,
    output logic       o_lr1,
    output logic       o_lg2,
    output logic       o_ly2,
    output logic       o_lr2,
    output logic       o_fault,
    output logic [1:0] o_fcode
);
    typedef enum logic [1:0] {
        ST_STARTUP     = 2'd0,
        ST_RUN         = 2'd1,
        ST_FAULT_FLASH = 2'd2
    } state_t;

    localparam logic [7:0] ST_LAST = 8'(STARTUP - 1);
    localparam logic [7:0] FH_LAST = 8'(FLASH_HALF - 1);
    localparam logic [7:0] DEB_TH  = 8'(CONFLICT_DEB);
    localparam logic [2:0] C_GRN   = 3'b100;
    localparam logic [2:0] C_YLW   = 3'b010;
    localparam logic [2:0] C_RED   = 3'b001;

    state_t     r_state, w_state_next;
    logic [5:0] r_s, r_lamp, w_lamp_next;
    logic [7:0] r_deb, w_deb_next;
    logic [7:0] r_scnt, w_scnt_next;
    logic [7:0] r_fcnt, w_fcnt_next;
    logic       r_phase, w_phase_next;
    logic       r_fault, w_fault_next;
    logic [1:0] r_fcode, w_fcode_next;
    logic [2:0] w_dir1, w_dir2;
    logic [1:0] w_n1, w_n2;
    logic       w_conflict, w_illegal, w_bad, w_deb_hit, w_ylw_viol, w_flash_next;

    // Checks operate on the registered sample S, never on the raw inputs.
    assign w_dir1     = r_s[5:3];
    assign w_dir2     = r_s[2:0];
    assign w_n1       = {1'b0, w_dir1[2]} + {1'b0, w_dir1[1]} + {1'b0, w_dir1[0]};
    assign w_n2       = {1'b0, w_dir2[2]} + {1'b0, w_dir2[1]} + {1'b0, w_dir2[0]};
    assign w_conflict = ~w_dir1[0] & ~w_dir2[0];
    assign w_illegal  = (w_n1 != 2'd1) | (w_n2 != 2'd1);
    assign w_bad      = w_conflict | w_illegal;

    // Debounce counts the bad sample being judged on this edge, so the fault lands on the DEB-th bad sample.
    assign w_deb_next = !w_bad ? 8'd0 : ((r_deb == 8'hFF) ? r_deb : r_deb + 8'd1);
    assign w_deb_hit  = (w_deb_next >= DEB_TH);

`ifdef MONITOR_YLW_EN
    localparam logic [7:0] YLW_TH = 8'(MIN_YLW);
    logic [2:0] r_prev1, r_prev2;
    logic [7:0] r_ycnt1, r_ycnt2;
    logic       w_viol1, w_viol2;

    // r_prev*/r_ycnt* describe the sample judged on the previous edge, so they pair with the current S.
    assign w_viol1    = (w_dir1 == C_RED) &&
                        ((r_prev1 == C_GRN) || ((r_prev1 == C_YLW) && (r_ycnt1 < YLW_TH)));
    assign w_viol2    = (w_dir2 == C_RED) &&
                        ((r_prev2 == C_GRN) || ((r_prev2 == C_YLW) && (r_ycnt2 < YLW_TH)));
    assign w_ylw_viol = w_viol1 | w_viol2;

    always_ff @(posedge i_ck or negedge i_clrn) begin
        if (!i_clrn) begin
            r_prev1 <= 3'b000;
            r_prev2 <= 3'b000;
            r_ycnt1 <= 8'd0;
            r_ycnt2 <= 8'd0;
        end else begin
            r_prev1 <= w_dir1;
            r_prev2 <= w_dir2;
            r_ycnt1 <= (w_dir1 != C_YLW) ? 8'd0 : ((r_ycnt1 >= YLW_TH) ? r_ycnt1 : r_ycnt1 + 8'd1);
            r_ycnt2 <= (w_dir2 != C_YLW) ? 8'd0 : ((r_ycnt2 >= YLW_TH) ? r_ycnt2 : r_ycnt2 + 8'd1);
        end
    end
`else
    assign w_ylw_viol = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_fault_next = r_fault;
        w_fcode_next = r_fcode;
        w_scnt_next  = 8'd0;
        case (r_state)
            ST_STARTUP: begin
                if (r_scnt >= ST_LAST) w_state_next = ST_RUN;
                else                   w_scnt_next  = r_scnt + 8'd1;
            end
            ST_RUN: begin
                if (w_deb_hit) begin
                    w_state_next = ST_FAULT_FLASH;
                    w_fault_next = 1'b1;
                    w_fcode_next = w_conflict ? 2'b01 : 2'b10;
                end else if (w_ylw_viol) begin
                    w_state_next = ST_FAULT_FLASH;
                    w_fault_next = 1'b1;
                    w_fcode_next = 2'b11;
                end
            end
            ST_FAULT_FLASH: begin
                if (i_fack && !w_bad) begin
                    w_state_next = ST_STARTUP;
                    w_fault_next = 1'b0;
                    w_fcode_next = 2'b00;
                end
            end
            default: w_state_next = ST_STARTUP;
        endcase

        // Flash phase restarts at 1 whenever a flash state is entered, including FAULT_FLASH -> STARTUP.
        w_flash_next = (w_state_next != ST_RUN);
        w_phase_next = 1'b1;
        w_fcnt_next  = 8'd0;
        if (w_flash_next && (w_state_next == r_state)) begin
            if (r_fcnt >= FH_LAST) begin
                w_phase_next = ~r_phase;
            end else begin
                w_phase_next = r_phase;
                w_fcnt_next  = r_fcnt + 8'd1;
            end
        end
        w_lamp_next = w_flash_next ? {2'b00, w_phase_next, 2'b00, w_phase_next} : r_s;
    end

    always_ff @(posedge i_ck or negedge i_clrn) begin
        if (!i_clrn) begin
            r_s     <= 6'b000000;
            r_state <= ST_STARTUP;
            r_deb   <= 8'd0;
            r_scnt  <= 8'd0;
            r_fcnt  <= 8'd0;
            r_phase <= 1'b1;
            r_fault <= 1'b0;
            r_fcode <= 2'b00;
            r_lamp  <= 6'b001001;
        end else begin
            r_s     <= {i_grn1, i_ylw1, i_red1, i_grn2, i_ylw2, i_red2};
            r_state <= w_state_next;
            r_deb   <= w_deb_next;
            r_scnt  <= w_scnt_next;
            r_fcnt  <= w_fcnt_next;
            r_phase <= w_phase_next;
            r_fault <= w_fault_next;
            r_fcode <= w_fcode_next;
            r_lamp  <= w_lamp_next;
        end
    end

    assign {o_lg1, o_ly1, o_lr1, o_lg2, o_ly2, o_lr2} = r_lamp;
    assign o_fault = r_fault;
    assign o_fcode = r_fcode;
endmodule
